rgb_seq_monitor: RTL and testbench
==================================

Name: rgb_seq_monitor

Overview:
- Receive-side checker for the one-hot RGB light sequencer. It watches the sequencer's red/green/blue lines and reconstructs complete frames: BLANK, then RED, GREEN, BLUE for one cycle each, then BLANK.
- Counts good frames, flags protocol violations and reports the decoded colour.
- Sits in the same clock domain as the sequencer. Used in-system as a health monitor and in benches as a scoreboard front-end.

Parameters:
- CNT_W, 8, width of frame_count and err_count; both saturate at all-ones.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- red  input  1  red light line from the sequencer.
- green  input  1  green light line from the sequencer.
- blue  input  1  blue light line from the sequencer.
- clear  input  1  synchronous clear of counters and sticky error.
- color  output  2  decoded registered sample: 00 blank, 01 red, 11 green, 10 blue (00 when multi-hot).
- busy  output  1  FSM is not in IDLE.
- frame_done  output  1  one-cycle pulse per completed good frame.
- frame_count  output  CNT_W  saturating count of good frames.
- err  output  1  one-cycle pulse per detected violation.
- err_cause  output  2  cause of the latest error: 01 multi-hot, 10 out-of-order; holds until the next error or clear.
- err_sticky  output  1  set by any err; cleared only by clear or reset.
- err_count  output  CNT_W  saturating count of err pulses.

Behaviour:
- Reset (reset_n low, async): every output and register is 0, and the FSM is in IDLE.
- Stage 1: {red,green,blue} is registered every cycle into the sample register s. color is decoded from s.
  - multi = two or more bits of s set.
- Stage 2: the FSM advances on every clk edge using s. frame_done, err, err_cause, busy and the counters are all registered.
- Latency: an input value present before edge N lands in s at N. Its FSM effect and output pulses are visible after edge N+1 (2 cycles from pin).
- FSM states: IDLE, SAW_R, SAW_G, SAW_B.
  - IDLE: blank -> IDLE. red -> SAW_R. green or blue -> error(10), stay IDLE.
  - SAW_R: green -> SAW_G. Anything else -> error.
  - SAW_G: blue -> SAW_B. Anything else -> error.
  - SAW_B: blank -> IDLE with frame_done=1 and frame_count+1. Anything else -> error.
  - Note: a RED immediately after BLUE, with no BLANK between, is an error.
- Error transition, from any state:
  - multi is checked first: cause 01, next state IDLE.
  - Otherwise cause 10. Next state is SAW_R if s is red (resync), else IDLE.
  - err pulses for one cycle, err_sticky is set, and err_count increments.
- A valid frame needs exactly one cycle each of R, G, B. A colour held for two cycles is an out-of-order error on the second cycle.
- Counters saturate at 2^CNT_W-1 with no wrap. Pulses continue at saturation.
- clear:
  - Zeroes frame_count, err_count, err_sticky and err_cause on the next edge.
  - Does not affect the FSM, s, or the frame_done/err pulses.
  - If clear coincides with an increment or sticky set, clear wins and the value becomes 0. The pulse still fires.
- busy = (state != IDLE).
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. A frame in progress is discarded, not counted.

Test Plan:
- Apply reset, then drive blank for 5 cycles. Required: all outputs 0, busy 0, no pulses.
- Drive one frame R,G,B,blank, one cycle each. Required: color shows 01,11,10,00 one cycle after each pin value. frame_done pulses exactly once, 2 cycles after the blank pin cycle. frame_count=1, err_sticky=0.
- Drive 300 back-to-back frames, each separated by exactly one blank cycle, with CNT_W=8. Required: frame_count saturates at 255, frame_done pulses 300 times, err_count=0.
- Drive red+green together while in IDLE. Required: err pulse, err_cause=01, color=00, err_count=1. Then drive G alone. Required: second err, err_cause=10, err_count=2, err_sticky=1.
- Drive R,G,R,G,B,blank. Required: one err (cause 10) on the second R. The FSM resyncs to SAW_R and the frame completes: frame_done once, frame_count=1.
- Drive R,G, assert reset_n low for one cycle, then B,blank. Required: outputs go to 0 immediately, no frame_done follows, and the B after reset raises err with cause 10.
- Assert clear in the same cycle as a frame_done pulse. Required: frame_done still pulses and frame_count reads 0 on the next cycle.

Source files
------------

// File: rtl/rgb_seq_monitor.sv
// -----------------------------------------------------------------------------
// rgb_seq_monitor
//
// Receive-side checker for the one-hot RGB light sequencer. A complete good
// frame on the light lines is BLANK, RED, GREEN, BLUE (one cycle each), BLANK.
// The monitor counts good frames, flags protocol violations and reports the
// decoded colour of the most recent sample.
//
// Pipeline:
//   stage 1 : {red,green,blue} registered into s_q every cycle; color decodes s_q
//   stage 2 : FSM, pulses, cause, sticky flag and counters, all registered from s_q
//   A pin value present before edge N is in s_q after N; its FSM effect and
//   pulses are visible after edge N+1.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   red/green/blue in light lines from the sequencer
//   clear        in   synchronous clear of counters, err_cause and err_sticky
//   color        out  [1:0] decoded sample: 00 blank/multi-hot, 01 red, 11 green, 10 blue
//   busy         out  FSM is part-way through a frame
//   frame_done   out  one-cycle pulse per completed good frame
//   frame_count  out  [CNT_W-1:0] saturating count of good frames
//   err          out  one-cycle pulse per violation
//   err_cause    out  [1:0] cause of latest error: 01 multi-hot, 10 out-of-order
//   err_sticky   out  set by any error, cleared by clear or reset
//   err_count    out  [CNT_W-1:0] saturating count of err pulses
// -----------------------------------------------------------------------------
module rgb_seq_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             red,
    input  logic             green,
    input  logic             blue,
    input  logic             clear,
    output logic [1:0]       color,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_count,
    output logic             err,
    output logic [1:0]       err_cause,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SAW_R = 2'd1;
    localparam logic [1:0] ST_SAW_G = 2'd2;
    localparam logic [1:0] ST_SAW_B = 2'd3;

    localparam logic [1:0] CAUSE_MULTI = 2'b01;
    localparam logic [1:0] CAUSE_ORDER = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1: sample register, bit order {red, green, blue}
    logic [2:0] s_q;

    // Stage 2 state
    logic [1:0]       state_q, state_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       cause_q, cause_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    // Sample classification. The single-colour terms are exact matches, so a
    // multi-hot sample never looks like a valid colour to the FSM.
    logic s_blank, s_red, s_green, s_blue, s_multi;
    logic bad;
    logic [1:0] new_cause;

    assign s_blank = (s_q == 3'b000);
    assign s_red   = (s_q == 3'b100);
    assign s_green = (s_q == 3'b010);
    assign s_blue  = (s_q == 3'b001);
    assign s_multi = (s_q[2] & s_q[1]) | (s_q[2] & s_q[0]) | (s_q[1] & s_q[0]);

    always_comb begin
        color = 2'b00;
        case (s_q)
            3'b100:  color = 2'b01;
            3'b010:  color = 2'b11;
            3'b001:  color = 2'b10;
            default: color = 2'b00;
        endcase
    end

    // Frame FSM: each state accepts exactly one next symbol; anything else
    // is funnelled into the common error handling below.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        bad       = 1'b0;
        err_d     = 1'b0;
        new_cause = CAUSE_ORDER;
        case (state_q)
            ST_IDLE: begin
                if (s_red) begin
                    state_d = ST_SAW_R;
                end else if (!s_blank) begin
                    bad = 1'b1;
                end
            end
            ST_SAW_R: begin
                if (s_green) state_d = ST_SAW_G;
                else         bad     = 1'b1;
            end
            ST_SAW_G: begin
                if (s_blue) state_d = ST_SAW_B;
                else        bad     = 1'b1;
            end
            ST_SAW_B: begin
                if (s_blank) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bad) begin
            err_d = 1'b1;
            if (s_multi) begin
                new_cause = CAUSE_MULTI;
                state_d   = ST_IDLE;
            end else begin
                new_cause = CAUSE_ORDER;
                // A stray red is treated as the start of a fresh frame.
                state_d   = s_red ? ST_SAW_R : ST_IDLE;
            end
        end
    end

    // Counters and status; clear overrides any same-cycle increment or set,
    // but never suppresses the pulses themselves.
    always_comb begin
        fcnt_d   = fcnt_q;
        ecnt_d   = ecnt_q;
        sticky_d = sticky_q;
        cause_d  = cause_q;
        if (clear) begin
            fcnt_d   = '0;
            ecnt_d   = '0;
            sticky_d = 1'b0;
            cause_d  = 2'b00;
        end else begin
            if (done_d && (fcnt_q != CNT_MAX)) begin
                fcnt_d = fcnt_q + CNT_ONE;
            end
            if (err_d) begin
                sticky_d = 1'b1;
                cause_d  = new_cause;
                if (ecnt_q != CNT_MAX) begin
                    ecnt_d = ecnt_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q      <= 3'b000;
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cause_q  <= 2'b00;
            sticky_q <= 1'b0;
            fcnt_q   <= '0;
            ecnt_q   <= '0;
        end else begin
            s_q      <= {red, green, blue};
            state_q  <= state_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cause_q  <= cause_d;
            sticky_q <= sticky_d;
            fcnt_q   <= fcnt_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = done_q;
    assign frame_count = fcnt_q;
    assign err         = err_q;
    assign err_cause   = cause_q;
    assign err_sticky  = sticky_q;
    assign err_count   = ecnt_q;

endmodule

// File: tb/tb_rgb_seq_monitor.sv
// -----------------------------------------------------------------------------
// tb_rgb_seq_monitor
//
// Self-checking bench for rgb_seq_monitor. A behavioural model tracks frame
// progress as "how many colours of the current frame have been seen" and
// derives the expected outputs from that count.
// -----------------------------------------------------------------------------
module tb_rgb_seq_monitor;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       red = 1'b0, green = 1'b0, blue = 1'b0;
    logic       clear = 1'b0;
    logic [1:0] color;
    logic       busy, frame_done, err, err_sticky;
    logic [7:0] frame_count, err_count;
    logic [1:0] err_cause;

    int n_checks = 0;
    int n_fail   = 0;

    rgb_seq_monitor #(.CNT_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .clear       (clear),
        .color       (color),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err         (err),
        .err_cause   (err_cause),
        .err_sticky  (err_sticky),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    logic [23:0] dut_vec;
    assign dut_vec = {color, busy, frame_done, frame_count, err, err_cause, err_sticky, err_count};

    // ---------------- reference model ----------------
    bit [2:0] m_s;       // last sampled pins
    int       m_prog;    // colours of the current frame seen so far (0..3)
    bit       m_done, m_err, m_sticky;
    bit [1:0] m_cause;
    int       m_fc, m_ec;

    function automatic bit [1:0] color_of(input bit [2:0] v);
        if (v == 3'b100) return 2'b01;
        if (v == 3'b010) return 2'b11;
        if (v == 3'b001) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [23:0] exp_vec();
        return {color_of(m_s), (m_prog != 0), m_done, 8'(m_fc), m_err, m_cause, m_sticky, 8'(m_ec)};
    endfunction

    task automatic model_reset();
        m_s = 0; m_prog = 0; m_done = 0; m_err = 0; m_sticky = 0;
        m_cause = 0; m_fc = 0; m_ec = 0;
    endtask

    // One clock edge: judge the previously sampled pins, then take new ones.
    task automatic model_edge(input bit clr, input bit [2:0] pins);
        bit [2:0] want;
        bit       e;
        bit [1:0] c;
        e = 0; c = 0; m_done = 0;
        want = (m_prog == 0) ? 3'b100 : (m_prog == 1) ? 3'b010 :
               (m_prog == 2) ? 3'b001 : 3'b000;
        if ($countones(m_s) >= 2) begin
            e = 1; c = 2'b01; m_prog = 0;
        end else if (m_prog == 0 && m_s == 3'b000) begin
            m_prog = 0;
        end else if (m_s == want) begin
            if (m_prog == 3) begin m_done = 1; m_prog = 0; end
            else m_prog = m_prog + 1;
        end else begin
            e = 1; c = 2'b10; m_prog = (m_s == 3'b100) ? 1 : 0;
        end
        m_err = e;
        if (clr) begin
            m_fc = 0; m_ec = 0; m_sticky = 0; m_cause = 0;
        end else begin
            if (m_done && m_fc < 255) m_fc = m_fc + 1;
            if (e) begin
                if (m_ec < 255) m_ec = m_ec + 1;
                m_sticky = 1;
                m_cause  = c;
            end
        end
        m_s = pins;
    endtask

    // ---------------- drivers ----------------
    task automatic step(input bit [2:0] rgb, input bit clr);
        @(negedge clk);
        {red, green, blue} = rgb;
        clear = clr;
        @(posedge clk);
        model_edge(clr, rgb);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        {red, green, blue} = 3'b000;
        clear = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(3'b000, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        {red, green, blue} = 3'b000;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== 24'h0) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, 24'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(3'b000, 1'b0);
            n_checks++;
            if (dut_vec !== 24'h0) begin
                n_fail++; $display("FAIL reset_blank[%0d]: got %h expected %h", i, dut_vec, 24'h0);
            end
        end
    endtask

    task automatic test_single_frame();
        bit [2:0] pins [6] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
        bit [1:0] cols [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int done_n, done_at;
        apply_reset();
        done_n = 0; done_at = -1;
        for (int i = 0; i < 6; i++) begin
            step(pins[i], 1'b0);
            if (i < 4) begin
                n_checks++;
                if (color !== cols[i]) begin
                    n_fail++; $display("FAIL single_color[%0d]: got %b expected %b", i, color, cols[i]);
                end
            end
            if (frame_done === 1'b1) begin done_n++; done_at = i; end
        end
        n_checks++;
        if (done_n != 1 || done_at != 4) begin
            n_fail++; $display("FAIL single_done: got %0d pulses at step %0d expected 1 at step 4", done_n, done_at);
        end
        n_checks++;
        if (frame_count !== 8'd1 || err_sticky !== 1'b0) begin
            n_fail++; $display("FAIL single_count: got count %0d sticky %b expected 1 and 0", frame_count, err_sticky);
        end
    endtask

    task automatic test_back_to_back();
        bit [2:0] seq [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
        int done_n, bad_n;
        apply_reset();
        done_n = 0; bad_n = 0;
        for (int i = 0; i < 300 * 4 + 2; i++) begin
            step((i < 1200) ? seq[i % 4] : 3'b000, 1'b0);
            if (frame_done === 1'b1) done_n++;
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                if (bad_n++ < 5) $display("FAIL b2b_step[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (frame_count !== 8'd255 || done_n != 300 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_saturate: got count %0d pulses %0d errs %0d expected 255 300 0",
                     frame_count, done_n, err_count);
        end
    endtask

    task automatic test_multi_hot();
        apply_reset();
        step(3'b110, 1'b0);
        n_checks++;
        if (color !== 2'b00) begin
            n_fail++; $display("FAIL multi_color: got %b expected 00", color);
        end
        step(3'b000, 1'b0);
        n_checks++;
        if ({err, err_cause, err_count} !== {1'b1, 2'b01, 8'd1}) begin
            n_fail++; $display("FAIL multi_err: got err %b cause %b count %0d expected 1 01 1", err, err_cause, err_count);
        end
        step(3'b010, 1'b0);
        n_checks++;
        if (err !== 1'b0 || color !== 2'b11) begin
            n_fail++; $display("FAIL multi_gap: got err %b color %b expected 0 11", err, color);
        end
        step(3'b000, 1'b0);
        n_checks++;
        if ({err, err_cause, err_count, err_sticky} !== {1'b1, 2'b10, 8'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL order_err: got err %b cause %b count %0d sticky %b expected 1 10 2 1",
                     err, err_cause, err_count, err_sticky);
        end
    endtask

    task automatic test_resync();
        bit [2:0] pins [8] = '{3'b100, 3'b010, 3'b100, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000};
        int err_n, err_at, done_n;
        bit [1:0] cause_seen;
        apply_reset();
        err_n = 0; err_at = -1; done_n = 0; cause_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(pins[i], 1'b0);
            if (err === 1'b1) begin err_n++; err_at = i; cause_seen = err_cause; end
            if (frame_done === 1'b1) done_n++;
        end
        n_checks++;
        if (err_n != 1 || err_at != 3 || cause_seen != 2'b10) begin
            n_fail++;
            $display("FAIL resync_err: got %0d errs at step %0d cause %b expected 1 at step 3 cause 10",
                     err_n, err_at, cause_seen);
        end
        n_checks++;
        if (done_n != 1 || frame_count !== 8'd1) begin
            n_fail++; $display("FAIL resync_done: got %0d pulses count %0d expected 1 and 1", done_n, frame_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        int done_n;
        apply_reset();
        step(3'b100, 1'b0);
        step(3'b010, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_busy: got %b expected 1", busy);
        end
        @(negedge clk);
        reset_n = 1'b0;
        {red, green, blue} = 3'b000;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== 24'h0) begin
            n_fail++; $display("FAIL midrst_zero: got %h expected %h", dut_vec, 24'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        {red, green, blue} = 3'b001;
        @(posedge clk);
        model_edge(1'b0, 3'b001);
        #1;
        done_n = (frame_done === 1'b1) ? 1 : 0;
        step(3'b000, 1'b0);
        if (frame_done === 1'b1) done_n++;
        n_checks++;
        if (err !== 1'b1 || err_cause !== 2'b10) begin
            n_fail++; $display("FAIL midrst_err: got err %b cause %b expected 1 10", err, err_cause);
        end
        step(3'b000, 1'b0);
        if (frame_done === 1'b1) done_n++;
        n_checks++;
        if (done_n != 0 || frame_count !== 8'd0) begin
            n_fail++; $display("FAIL midrst_nodone: got %0d pulses count %0d expected 0 and 0", done_n, frame_count);
        end
    endtask

    task automatic test_clear_on_done();
        bit [2:0] seq [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
        apply_reset();
        for (int i = 0; i < 4; i++) step(seq[i], 1'b0);
        step(3'b000, 1'b0);
        n_checks++;
        if (frame_done !== 1'b1 || frame_count !== 8'd1) begin
            n_fail++; $display("FAIL clr_pre: got done %b count %0d expected 1 1", frame_done, frame_count);
        end
        for (int i = 0; i < 4; i++) step(seq[i], 1'b0);
        step(3'b000, 1'b1);
        n_checks++;
        if (frame_done !== 1'b1 || frame_count !== 8'd0) begin
            n_fail++; $display("FAIL clr_on_done: got done %b count %0d expected 1 0", frame_done, frame_count);
        end
        step(3'b000, 1'b0);
        n_checks++;
        if (frame_done !== 1'b0 || frame_count !== 8'd0) begin
            n_fail++; $display("FAIL clr_after: got done %b count %0d expected 0 0", frame_done, frame_count);
        end
    endtask

    task automatic test_random();
        bit [2:0] seq [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
        int gp, bad_n;
        bit [2:0] p;
        bit c;
        apply_reset();
        gp = 0; bad_n = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                p = seq[gp];
                gp = (gp + 1) % 4;
            end else begin
                p = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) gp = 0;
            end
            c = ($urandom_range(0, 29) == 0);
            step(p, c);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                if (bad_n++ < 5) $display("FAIL random_step[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_multi_hot();
        test_resync();
        test_reset_mid_frame();
        test_clear_on_done();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
